// File: rtl/drive_arbiter_pkg.sv
// Shared drive-train encodings for drive_arbiter: motor direction codes, arbiter FSM states
// and the duty-code width.
package drive_arbiter_pkg;

    localparam int DUTY_W = 2;

    // Direction code is {FWD, BWD} as presented to the PWM encoder.
    localparam logic [1:0] DIR_COAST   = 2'b00;
    localparam logic [1:0] DIR_BWD     = 2'b01;
    localparam logic [1:0] DIR_FWD     = 2'b10;
    localparam logic [1:0] DIR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    function automatic logic [1:0] sanitize_dir(input logic [1:0] d);
        return (d == DIR_ILLEGAL) ? DIR_COAST : d;
    endfunction

endpackage

// File: rtl/drive_arbiter_motor_deadtime.sv
// One motor channel: applies commanded direction/duty, inserting coast dead-time on reversals.
// Optional duty soft-start is enabled with `define DRIVE_ARB_RAMP_EN.
module drive_arbiter_motor_deadtime
    import drive_arbiter_pkg::*;
#(
    parameter int DEADTIME_CYC = 100000,
    parameter int RAMP_CYC     = 250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic              pause,
    input  logic [1:0]        cmd_dir,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic [1:0]        dir,
    output logic [DUTY_W-1:0] duty,
    output logic              dead_time,
    output logic              fault
);

    localparam int CNT_W = $clog2(DEADTIME_CYC + 1);

    if (DEADTIME_CYC < 1 || RAMP_CYC < 1) begin : g_param_check
        $error("drive_arbiter_motor_deadtime: DEADTIME_CYC and RAMP_CYC must be >= 1");
    end

    logic [CNT_W-1:0]  dt_cnt;
    logic [1:0]        c_dir;
    logic              illegal;
    logic              illegal_q;
    logic [DUTY_W-1:0] start_duty;
    logic [DUTY_W-1:0] run_duty;

    assign illegal = (cmd_dir == DIR_ILLEGAL);
    assign c_dir   = sanitize_dir(cmd_dir);

`ifdef DRIVE_ARB_RAMP_EN
    localparam int RAMP_W = $clog2(RAMP_CYC + 1);

    logic [RAMP_W-1:0] ramp_cnt;
    logic [RAMP_W-1:0] ramp_nxt;
    logic              steady;

    // Drive starts at the lowest non-zero code; increases step once per RAMP_CYC, decreases are immediate.
    always_comb begin
        start_duty = (cmd_duty == '0) ? '0 : DUTY_W'(1);
        run_duty   = duty;
        ramp_nxt   = '0;
        if (cmd_duty <= duty) begin
            run_duty = cmd_duty;
        end else if (ramp_cnt == RAMP_W'(RAMP_CYC - 1)) begin
            run_duty = duty + DUTY_W'(1);
        end else begin
            ramp_nxt = ramp_cnt + RAMP_W'(1);
        end
    end

    assign steady = active && !pause && !dead_time && (c_dir == dir) && (dir != DIR_COAST);

    always_ff @(posedge clk) begin
        if (!rst_n || !steady) ramp_cnt <= '0;
        else                   ramp_cnt <= ramp_nxt;
    end
`else
    assign start_duty = cmd_duty;
    assign run_duty   = cmd_duty;
`endif

    // Applied dir/duty register stage; dead-time counter runs only while the channel is owned.
    always_ff @(posedge clk) begin
        if (!rst_n || !active || pause) begin
            dir       <= DIR_COAST;
            duty      <= '0;
            dt_cnt    <= '0;
            dead_time <= 1'b0;
            illegal_q <= 1'b0;
            fault     <= 1'b0;
        end else begin
            fault     <= illegal && !illegal_q;
            illegal_q <= illegal;
            if (dead_time) begin
                if (c_dir == DIR_COAST) begin
                    dead_time <= 1'b0;
                    dt_cnt    <= '0;
                end else if (dt_cnt > CNT_W'(1)) begin
                    dt_cnt <= dt_cnt - CNT_W'(1);
                end else begin
                    dead_time <= 1'b0;
                    dt_cnt    <= '0;
                    dir       <= c_dir;
                    duty      <= start_duty;
                end
            end else if (c_dir == DIR_COAST) begin
                dir  <= DIR_COAST;
                duty <= '0;
            end else if (c_dir == dir) begin
                duty <= run_duty;
            end else if (dir == DIR_COAST) begin
                dir  <= c_dir;
                duty <= start_duty;
            end else begin
                dir       <= DIR_COAST;
                duty      <= '0;
                dt_cnt    <= CNT_W'(DEADTIME_CYC);
                dead_time <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/drive_arbiter.sv
// Grants the shared drive train to one direction controller and applies per-motor dead-time and Pause.
// Optional duty soft-start: `define DRIVE_ARB_RAMP_EN.
module drive_arbiter
    import drive_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int DEADTIME_CYC = 100000,
    parameter int RAMP_CYC     = 250000
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [NUM_REQ-1:0]   Req,
    input  logic [2*NUM_REQ-1:0] Cmd_DirA,
    input  logic [2*NUM_REQ-1:0] Cmd_DirB,
    input  logic [2*NUM_REQ-1:0] Cmd_DutyA,
    input  logic [2*NUM_REQ-1:0] Cmd_DutyB,
    input  logic                 Pause,
    output logic [NUM_REQ-1:0]   Grant,
    output logic                 FWD_A,
    output logic                 BWD_A,
    output logic                 FWD_B,
    output logic                 BWD_B,
    output logic [DUTY_W-1:0]    Duty_SelA,
    output logic [DUTY_W-1:0]    Duty_SelB,
    output logic [1:0]           DeadTime,
    output logic                 Cmd_Fault
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt, pick_idx;
    logic             owner_req;
    logic             active;
    logic [1:0]       dir_a, dir_b;
    logic             dt_a, dt_b, fault_a, fault_b;

    // Fixed priority: lowest set index wins.
    always_comb begin
        pick_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (Req[i]) pick_idx = IDX_W'(i);
        end
    end

    assign owner_req = Req[owner];
    assign active    = (state == ST_GRANT) && owner_req;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            ST_IDLE: begin
                if (|Req) begin
                    state_nxt = ST_GRANT;
                    owner_nxt = pick_idx;
                end
            end
            ST_GRANT:   if (!owner_req) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state <= ST_IDLE;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        Grant = '0;
        if (state == ST_GRANT) Grant[owner] = 1'b1;
    end

    // Only the owner's command slice reaches the motor channels.
    drive_arbiter_motor_deadtime #(
        .DEADTIME_CYC(DEADTIME_CYC),
        .RAMP_CYC    (RAMP_CYC)
    ) u_motor_a (
        .clk      (clk),
        .rst_n    (Reset),
        .active   (active),
        .pause    (Pause),
        .cmd_dir  (Cmd_DirA[{owner, 1'b0} +: 2]),
        .cmd_duty (Cmd_DutyA[{owner, 1'b0} +: DUTY_W]),
        .dir      (dir_a),
        .duty     (Duty_SelA),
        .dead_time(dt_a),
        .fault    (fault_a)
    );

    drive_arbiter_motor_deadtime #(
        .DEADTIME_CYC(DEADTIME_CYC),
        .RAMP_CYC    (RAMP_CYC)
    ) u_motor_b (
        .clk      (clk),
        .rst_n    (Reset),
        .active   (active),
        .pause    (Pause),
        .cmd_dir  (Cmd_DirB[{owner, 1'b0} +: 2]),
        .cmd_duty (Cmd_DutyB[{owner, 1'b0} +: DUTY_W]),
        .dir      (dir_b),
        .duty     (Duty_SelB),
        .dead_time(dt_b),
        .fault    (fault_b)
    );

    assign FWD_A     = dir_a[1];
    assign BWD_A     = dir_a[0];
    assign FWD_B     = dir_b[1];
    assign BWD_B     = dir_b[0];
    assign DeadTime  = {dt_b, dt_a};
    assign Cmd_Fault = fault_a | fault_b;

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed table-driven bench for drive_arbiter with DEADTIME_CYC=4, RAMP_CYC=3 (ramp disabled).
module tb_drive_arbiter;

    logic       clk;
    logic       Reset;
    logic [2:0] Req;
    logic [5:0] Cmd_DirA, Cmd_DirB, Cmd_DutyA, Cmd_DutyB;
    logic       Pause;
    logic [2:0] Grant;
    logic       FWD_A, BWD_A, FWD_B, BWD_B;
    logic [1:0] Duty_SelA, Duty_SelB, DeadTime;
    logic       Cmd_Fault;

    int n_checks = 0;
    int n_fail   = 0;

    drive_arbiter #(
        .NUM_REQ     (3),
        .DEADTIME_CYC(4),
        .RAMP_CYC    (3)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .Req      (Req),
        .Cmd_DirA (Cmd_DirA),
        .Cmd_DirB (Cmd_DirB),
        .Cmd_DutyA(Cmd_DutyA),
        .Cmd_DutyB(Cmd_DutyB),
        .Pause    (Pause),
        .Grant    (Grant),
        .FWD_A    (FWD_A),
        .BWD_A    (BWD_A),
        .FWD_B    (FWD_B),
        .BWD_B    (BWD_B),
        .Duty_SelA(Duty_SelA),
        .Duty_SelB(Duty_SelB),
        .DeadTime (DeadTime),
        .Cmd_Fault(Cmd_Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied before an edge, expected outputs sampled 1 time unit after it.
    typedef struct {
        logic       rst_n;
        logic       pause;
        logic [2:0] req;
        logic [5:0] dira;
        logic [5:0] dirb;
        logic [5:0] dutya;
        logic [5:0] dutyb;
        logic [2:0] e_grant;
        logic [1:0] e_a;
        logic [1:0] e_da;
        logic [1:0] e_b;
        logic [1:0] e_db;
        logic [1:0] e_dt;
        logic       e_fault;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input int idx, input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %0h expected %0h", idx, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        Reset     = v.rst_n;
        Pause     = v.pause;
        Req       = v.req;
        Cmd_DirA  = v.dira;
        Cmd_DirB  = v.dirb;
        Cmd_DutyA = v.dutya;
        Cmd_DutyB = v.dutyb;
        @(posedge clk);
        #1;
        check(idx, "grant",    8'(Grant),              8'(v.e_grant));
        check(idx, "dir_a",    8'({FWD_A, BWD_A}),     8'(v.e_a));
        check(idx, "duty_a",   8'(Duty_SelA),          8'(v.e_da));
        check(idx, "dir_b",    8'({FWD_B, BWD_B}),     8'(v.e_b));
        check(idx, "duty_b",   8'(Duty_SelB),          8'(v.e_db));
        check(idx, "deadtime", 8'(DeadTime),           8'(v.e_dt));
        check(idx, "fault",    8'(Cmd_Fault),          8'(v.e_fault));
    endtask

    initial begin
        // rst pause req dira dirb dutya dutyb | grant a da b db dt fault
        vecs[0]  = '{1'b0, 1'b0, 3'b000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 3'b000, 2'b00, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 3'b000, 2'b00, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b110, 6'b011000, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b00, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b111, 6'b011000, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b10, 2'd2, 2'b01, 2'd3, 2'b00, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b111, 6'b011000, 6'b000100, 6'b000100, 6'b001100, 3'b010, 2'b10, 2'd1, 2'b01, 2'd3, 2'b00, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b111, 6'b010100, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b00, 2'd0, 2'b01, 2'd3, 2'b01, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b111, 6'b010100, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b00, 2'd0, 2'b01, 2'd3, 2'b01, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'b111, 6'b010100, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b00, 2'd0, 2'b01, 2'd3, 2'b01, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b111, 6'b010100, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b00, 2'd0, 2'b01, 2'd3, 2'b01, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'b111, 6'b010100, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b01, 2'd2, 2'b01, 2'd3, 2'b00, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'b111, 6'b010100, 6'b001000, 6'b001000, 6'b001100, 3'b010, 2'b01, 2'd2, 2'b00, 2'd0, 2'b10, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'b111, 6'b010100, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b01, 2'd2, 2'b00, 2'd0, 2'b10, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 3'b111, 6'b010100, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b00, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 3'b111, 6'b010100, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b01, 2'd2, 2'b01, 2'd3, 2'b00, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 3'b111, 6'b011100, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b00, 2'd0, 2'b01, 2'd3, 2'b00, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 3'b111, 6'b011100, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b00, 2'd0, 2'b01, 2'd3, 2'b00, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 3'b111, 6'b011000, 6'b000100, 6'b001000, 6'b001100, 3'b010, 2'b10, 2'd2, 2'b01, 2'd3, 2'b00, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 3'b111, 6'b111000, 6'b000111, 6'b001000, 6'b001100, 3'b010, 2'b10, 2'd2, 2'b01, 2'd3, 2'b00, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 3'b111, 6'b010100, 6'b000111, 6'b001000, 6'b001100, 3'b010, 2'b00, 2'd0, 2'b01, 2'd3, 2'b01, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 3'b111, 6'b010000, 6'b000111, 6'b001000, 6'b001100, 3'b010, 2'b00, 2'd0, 2'b01, 2'd3, 2'b00, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 3'b101, 6'b010000, 6'b000100, 6'b001000, 6'b001100, 3'b000, 2'b00, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 3'b101, 6'b010000, 6'b000100, 6'b001000, 6'b001100, 3'b000, 2'b00, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 3'b101, 6'b010000, 6'b000100, 6'b001000, 6'b001100, 3'b001, 2'b00, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 3'b101, 6'b010010, 6'b000100, 6'b001011, 6'b001100, 3'b001, 2'b10, 2'd3, 2'b00, 2'd0, 2'b00, 1'b0};

        for (int i = 0; i < 24; i++) begin
            apply(vecs[i], i);
        end

        // Reset while motor A sits in dead-time: everything clears, and the next drive needs no dead-time.
        apply('{1'b1, 1'b0, 3'b101, 6'b010001, 6'b000100, 6'b001011, 6'b001100, 3'b001, 2'b00, 2'd0, 2'b00, 2'd0, 2'b01, 1'b0}, 100);
        apply('{1'b1, 1'b0, 3'b101, 6'b010001, 6'b000100, 6'b001011, 6'b001100, 3'b001, 2'b00, 2'd0, 2'b00, 2'd0, 2'b01, 1'b0}, 101);
        apply('{1'b0, 1'b0, 3'b101, 6'b010001, 6'b000100, 6'b001011, 6'b001100, 3'b000, 2'b00, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0}, 102);
        apply('{1'b1, 1'b0, 3'b101, 6'b010001, 6'b000100, 6'b001011, 6'b001100, 3'b001, 2'b00, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0}, 103);
        apply('{1'b1, 1'b0, 3'b101, 6'b010001, 6'b000100, 6'b001011, 6'b001100, 3'b001, 2'b01, 2'd3, 2'b00, 2'd0, 2'b00, 1'b0}, 104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
